// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous input; RESET_VAL sets the idle level.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output, framing-error and overrun pulses.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          rx_s;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s)
            state <= START;
        end

        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            par_bad    <= (rx_s != ^shreg);
            parity_err <= (rx_s != ^shreg);
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (!par_bad) begin
`else
              begin
`endif
                // A commit in the handshake cycle overrides the clear above.
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BREAK: begin
          cnt <= '0;
          if (rx_s)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; parity scenarios build with UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int rise_cnt, fe_cnt, ov_cnt, pe_cnt, valid_cycles, first_rise_cyc;
  logic [7:0] got_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // Observe just after each falling edge: outputs are settled, inputs show what the next edge will see.
  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
    end
    if (rx_valid) valid_cycles++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
    if (!reset && prev_valid && rx_valid && !prev_hs) begin
      n_checks++;
      if (rx_data !== prev_data) begin
        n_fail++;
        $display("FAIL data_stable: rx_data=%02h held=%02h at cycle %0d", rx_data, prev_data, cyc);
      end
    end
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    prev_valid = rx_valid;
    prev_hs    = rx_valid && rx_ready;
    prev_data  = rx_data;
  end

  task automatic clear_mon();
    rise_cnt = 0; fe_cnt = 0; ov_cnt = 0; pe_cnt = 0;
    valid_cycles = 0; first_rise_cyc = -1;
    got_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit = 1'b1, input logic par_flip = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_bit);
  endtask

  task automatic check_one_byte(input string name, input logic [7:0] exp);
    n_checks++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL %s_count: got %0d bytes, expected 1", name, got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== exp) begin
        n_fail++;
        $display("FAIL %s_data: got %02h, expected %02h", name, got_q[0], exp);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, expected 00", rx_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
  endtask

  task automatic test_single();
    int start_cyc;
    clear_mon();
    rx_ready = 1'b1;
    start_cyc = cyc;
    send_frame(8'h55);
    idle(4);
    check_one_byte("single", 8'h55);
    n_checks++; if (valid_cycles !== 1) begin n_fail++; $display("FAIL single_valid_width: got %0d cycles, expected 1", valid_cycles); end
    n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d pulses, expected 0", fe_cnt); end
    n_checks++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL single_overrun: got %0d pulses, expected 0", ov_cnt); end
    // Expected about 9.5 bit times plus synchroniser/register latency from the start edge.
    n_checks++;
    if (first_rise_cyc < 0 || (first_rise_cyc - start_cyc) < 9*CPB + CPB/2 || (first_rise_cyc - start_cyc) > 9*CPB + CPB/2 + 8) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles, expected %0d..%0d", first_rise_cyc - start_cyc, 9*CPB + CPB/2, 9*CPB + CPB/2 + 8);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'hA3);
    send_frame(8'h0F);
    idle(4);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_held: got %b, expected 1", rx_valid); end
    n_checks++; if (rx_data !== 8'hA3) begin n_fail++; $display("FAIL b2b_data_held: got %02h, expected a3", rx_data); end
    n_checks++; if (ov_cnt !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses, expected 1", ov_cnt); end
    rx_ready = 1'b1;
    idle(1);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b, expected 0", rx_valid); end
    check_one_byte("b2b", 8'hA3);
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    n_checks++; if (rise_cnt !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d bytes, expected 0", rise_cnt); end
    n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d pulses, expected 0", fe_cnt); end
    send_frame(8'h3C);
    idle(4);
    check_one_byte("after_glitch", 8'h3C);
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h81, 1'b0);
    idle(40);
    n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulses, expected 1", fe_cnt); end
    n_checks++; if (rise_cnt !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d bytes, expected 0", rise_cnt); end
    rx = 1'b1;
    idle(20);
    n_checks++; if (fe_cnt !== 1 || rise_cnt !== 0) begin n_fail++; $display("FAIL ferr_break: got %0d pulses %0d bytes, expected 1 and 0", fe_cnt, rise_cnt); end
    send_frame(8'h7E);
    idle(4);
    check_one_byte("after_ferr", 8'h7E);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(4*CPB + CPB/2);
    reset = 1'b1;
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %02h, expected 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b, expected 0", rx_valid); end
    idle(3);
    reset = 1'b0;
    idle(5*CPB);
    n_checks++; if (rise_cnt !== 0 || fe_cnt !== 0) begin n_fail++; $display("FAIL midreset_partial: got %0d bytes %0d frame errors, expected 0 and 0", rise_cnt, fe_cnt); end
    send_frame(8'h12);
    idle(4);
    check_one_byte("after_reset", 8'h12);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_fe, exp_pe;
    logic [7:0] d;
    logic bad_stop, bad_par;
    clear_mon();
    exp_fe = 0;
    exp_pe = 0;
    rx_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 7) == 0);
      bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_par = ($urandom_range(0, 5) == 0);
      if (bad_par) exp_pe++;
`endif
      send_frame(d, !bad_stop, bad_par);
      if (bad_stop) exp_fe++;
      else if (!bad_par) exp_q.push_back(d);
      rx = 1'b1;
      // A broken stop bit needs the line to return high before the next start.
      idle(bad_stop ? 4 + int'($urandom_range(0, 8)) : int'($urandom_range(0, 12)));
    end
    idle(4);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_data[%0d]: got %02h, expected %02h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_checks++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL random_frame_err: got %0d pulses, expected %0d", fe_cnt, exp_fe); end
    n_checks++; if (pe_cnt !== exp_pe) begin n_fail++; $display("FAIL random_parity_err: got %0d pulses, expected %0d", pe_cnt, exp_pe); end
    n_checks++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL random_overrun: got %0d pulses, expected 0", ov_cnt); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    n_checks++; if (pe_cnt !== 1) begin n_fail++; $display("FAIL parity_pulse: got %0d pulses, expected 1", pe_cnt); end
    n_checks++; if (rise_cnt !== 0) begin n_fail++; $display("FAIL parity_discard: got %0d bytes, expected 0", rise_cnt); end
    clear_mon();
    send_frame(8'h07);
    idle(4);
    n_checks++; if (pe_cnt !== 0) begin n_fail++; $display("FAIL parity_good_pulse: got %0d pulses, expected 0", pe_cnt); end
    check_one_byte("parity_good", 8'h07);
  endtask
`endif

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    idle(5);
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, 8N1, LSB-first; the receive-side counterpart to the board's UART transmit path. Synchronises the raw RX pin, detects and validates start bits, samples each bit at mid-bit and delivers bytes over a valid/ready handshake. Reports framing errors and overruns. Sits between the top-level RX pin and any byte consumer (FIFO, command parser, echo logic).

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate in bits/s.
CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE (integer division); must be at least 4.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
rx  input  1  raw serial line; idles high; asynchronous to clk.
rx_data  output  8  received byte; valid while rx_valid is high.
rx_valid  output  1  a byte is held in the output register.
rx_ready  input  1  consumer accepts the byte when rx_valid and rx_ready are both high on a clock edge.
frame_err  output  1  one-cycle pulse when a stop bit samples low.
overrun  output  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE, sync flops=1.
- rx passes through a 2-FF synchroniser (reset to 1); all logic uses the synchronised value rx_s.
- Bit-timing counter runs 0..CLKS_PER_BIT-1. The half-bit point is CLKS_PER_BIT/2.
- FSM states:
  - IDLE: wait for rx_s==0, then go to START with the counter cleared.
  - START: at the half-bit point, if rx_s==0, go to DATA with the counter cleared and bit index 0. If rx_s==1, it was a glitch: return to IDLE.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), shift rx_s into bit[idx], LSB first. After idx 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles (mid stop bit):
    - rx_s==1: commit the byte and go to IDLE.
    - rx_s==0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- Commit rules:
  - If rx_valid==0, or rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid=1.
  - If rx_valid && !rx_ready: the old byte is kept, the new byte is dropped, and overrun pulses for 1 cycle.
- rx_valid clears on the handshake cycle unless a commit happens in that same cycle. Commit wins: rx_valid stays 1 with the new data.
- rx_data must be stable while rx_valid==1 and no handshake has occurred.
- Latency: rx_valid rises 1 clk after the mid-stop-bit sample. This is about 9.5 bit times plus 3 clk after the start edge reaches the pin.
- Back-to-back frames: returning to IDLE at mid-stop leaves half a bit of margin to catch the next start edge.
- Reset mid-frame aborts immediately with no partial output. After reset, the FSM sits in IDLE; if the line is low, the next start is taken only on a low rx_s.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP, sampled mid-bit. There is an extra output parity_err (1 bit), a one-cycle pulse on mismatch against even parity of the data. On mismatch the byte is discarded and the STOP state is still checked.
- Undefined: 8N1 with no parity_err port.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE, START, DATA, PARITY, STOP, BREAK) and a CLKS_PER_BIT helper constant function, shared with the transmitter.
- One natural sub-module: uart_sync, a 2-FF synchroniser with reset value parameter, reusable for other async pins.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD_RATE=1, giving CLKS_PER_BIT=16.
1. Send 0x55 with rx_ready=1 -> rx_data=0x55, rx_valid high for exactly 1 clk, frame_err=0, overrun=0.
2. Send 0xA3 then 0x0F back-to-back with rx_ready=0 -> rx_data remains 0xA3 with rx_valid=1, and overrun pulses once at the 0x0F commit. Raise rx_ready -> rx_valid drops the next clk.
3. Drive rx low for 4 clk then high -> no rx_valid and no frame_err; the FSM returns to IDLE. Then send 0x3C -> received correctly.
4. Send 0x81 with the stop bit driven low and the line held low for 40 clk -> frame_err pulses once, rx_valid stays 0, and no spurious byte. Line goes high, then send 0x7E -> 0x7E received.
5. Assert reset in the middle of bit 4 of 0xFF -> outputs go to reset values. Release reset and send 0x12 -> 0x12 received.
6. With UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 (wrong) -> parity_err pulse, no rx_valid. Send 0x07 with parity bit 1 -> rx_data=0x07.
